// File: rtl/pipe_mem_pkg.sv
// Shared types and sizing for the unified IF/MEM memory arbiter.
package pipe_mem_pkg;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_t;

    localparam int CNT_W      = 3;
    localparam int RD_LAT_MAX = 4;
    localparam int STARVE_W   = 4;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: MEM wins by default, IF wins once it has been starved too long.
module mem_arb_pick (
    input  logic if_req,
    input  logic mem_req,
    input  logic starve_hit,
    input  logic eligible,
    output logic if_gnt,
    output logic mem_gnt
);

    always_comb begin
        if_gnt  = 1'b0;
        mem_gnt = 1'b0;
        if (eligible) begin
            if (if_req && (starve_hit || !mem_req)) begin
                if_gnt = 1'b1;
            end else if (mem_req) begin
                mem_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Shares one single-ported synchronous RAM between the IF and MEM pipeline stages,
// tracking the single outstanding read and steering its data back to its owner.
module pipe_mem_arbiter
    import pipe_mem_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          mem_req,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_wdata,
    output logic          mem_gnt,
    output logic          mem_rvalid,
    output logic [DW-1:0] mem_rdata,
    output logic          ram_cs,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout,
    output logic          stall_if,
    output logic          stall_mem,
    output logic          busy
);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    owner_t              owner_q, owner_d;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic eligible;
    logic starve_hit;
    logic pick_if;
    logic pick_mem;
    logic read_gnt;
    logic rd_ret;
    logic rd_pending;

    // Gating with rst_n keeps every handshake output quiet for the whole reset cycle.
    assign eligible   = rst_n && (cnt_q <= CNT_W'(1));
    assign starve_hit = (starve_q == STARVE_W'(STARVE_MAX));

    mem_arb_pick u_pick (
        .if_req     (if_req),
        .mem_req    (mem_req),
        .starve_hit (starve_hit),
        .eligible   (eligible),
        .if_gnt     (pick_if),
        .mem_gnt    (pick_mem)
    );

    assign read_gnt = pick_if || (pick_mem && !mem_we);

    always_comb begin
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        starve_d = starve_q;

        if (read_gnt) begin
            cnt_d   = CNT_W'(RD_LAT);
            owner_d = pick_if ? OWN_IF : OWN_MEM;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end

        if (!if_req || pick_if) begin
            starve_d = '0;
        end else if (!starve_hit) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            owner_q  <= OWN_IF;
            starve_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end

    assign if_gnt  = pick_if;
    assign mem_gnt = pick_mem;

    assign ram_cs   = pick_if || pick_mem;
    assign ram_we   = pick_mem && mem_we;
    assign ram_addr = pick_mem ? mem_addr : if_addr;
    assign ram_din  = mem_wdata;

    // The return cycle is cnt==1; anything larger means the read is still in the RAM pipeline.
    assign rd_ret     = rst_n && (cnt_q == CNT_W'(1));
    assign rd_pending = rst_n && (cnt_q > CNT_W'(1));

    assign if_rvalid  = rd_ret && (owner_q == OWN_IF);
    assign mem_rvalid = rd_ret && (owner_q == OWN_MEM);
    assign if_rdata   = ram_dout;
    assign mem_rdata  = ram_dout;

    assign busy      = rd_pending;
    assign stall_if  = rst_n && ((if_req && !pick_if) || ((owner_q == OWN_IF) && rd_pending));
    assign stall_mem = rst_n && ((mem_req && !pick_mem) || ((owner_q == OWN_MEM) && rd_pending));

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench: one arbiter with single-cycle RAM latency and one with three-cycle latency.
module tb_pipe_mem_arbiter;

    logic clk = 1'b0;
    logic rst_n;

    logic        if_req1, if_gnt1, if_rvalid1;
    logic [31:0] if_addr1, if_rdata1;
    logic        mem_req1, mem_we1, mem_gnt1, mem_rvalid1;
    logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;
    logic        ram_cs1, ram_we1;
    logic [31:0] ram_addr1, ram_din1, ram_dout1;
    logic        stall_if1, stall_mem1, busy1;

    logic        if_req3, if_gnt3, if_rvalid3;
    logic [31:0] if_addr3, if_rdata3;
    logic        mem_req3, mem_we3, mem_gnt3, mem_rvalid3;
    logic [31:0] mem_addr3, mem_wdata3, mem_rdata3;
    logic        ram_cs3, ram_we3;
    logic [31:0] ram_addr3, ram_din3, ram_dout3;
    logic        stall_if3, stall_mem3, busy3;

    logic [31:0] mem1 [0:63];
    logic [31:0] mem3 [0:63];
    logic [31:0] pipe1;
    logic [31:0] pipe3 [0:2];
    logic        mem_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .STARVE_MAX(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req1), .if_addr(if_addr1), .if_gnt(if_gnt1),
        .if_rvalid(if_rvalid1), .if_rdata(if_rdata1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_gnt(mem_gnt1),
        .mem_rvalid(mem_rvalid1), .mem_rdata(mem_rdata1),
        .ram_cs(ram_cs1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_din(ram_din1), .ram_dout(ram_dout1),
        .stall_if(stall_if1), .stall_mem(stall_mem1), .busy(busy1)
    );

    pipe_mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .STARVE_MAX(4)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
        .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
        .mem_req(mem_req3), .mem_we(mem_we3), .mem_addr(mem_addr3),
        .mem_wdata(mem_wdata3), .mem_gnt(mem_gnt3),
        .mem_rvalid(mem_rvalid3), .mem_rdata(mem_rdata3),
        .ram_cs(ram_cs3), .ram_we(ram_we3), .ram_addr(ram_addr3),
        .ram_din(ram_din3), .ram_dout(ram_dout3),
        .stall_if(stall_if3), .stall_mem(stall_mem3), .busy(busy3)
    );

    // RAM models: word index from addr[7:2], each word preset to 0xC0DE0000 + index.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) begin
                mem1[i] <= 32'hC0DE_0000 + i;
                mem3[i] <= 32'hC0DE_0000 + i;
            end
            mem_ready <= 1'b1;
        end else begin
            if (ram_cs1 && ram_we1) mem1[ram_addr1[7:2]] <= ram_din1;
            if (ram_cs3 && ram_we3) mem3[ram_addr3[7:2]] <= ram_din3;
        end
        pipe1    <= mem1[ram_addr1[7:2]];
        pipe3[0] <= mem3[ram_addr3[7:2]];
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end

    assign ram_dout1 = pipe1;
    assign ram_dout3 = pipe3[2];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive after the rising edge, return at the falling edge for sampling.
    task automatic applyStimulus(input logic rst_val, input bit to3,
                                 input logic i_req, input logic [31:0] i_addr,
                                 input logic m_req, input logic m_we,
                                 input logic [31:0] m_addr, input logic [31:0] m_wdata);
        @(posedge clk);
        #1;
        rst_n      = rst_val;
        if_req1    = to3 ? 1'b0 : i_req;
        if_addr1   = i_addr;
        mem_req1   = to3 ? 1'b0 : m_req;
        mem_we1    = m_we;
        mem_addr1  = m_addr;
        mem_wdata1 = m_wdata;
        if_req3    = to3 ? i_req : 1'b0;
        if_addr3   = i_addr;
        mem_req3   = to3 ? m_req : 1'b0;
        mem_we3    = m_we;
        mem_addr3  = m_addr;
        mem_wdata3 = m_wdata;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        {if_req1, mem_req1, mem_we1, if_req3, mem_req3, mem_we3} = '0;
        {if_addr1, mem_addr1, mem_wdata1, if_addr3, mem_addr3, mem_wdata3} = '0;

        // Reset with requests present: everything must stay quiet.
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0020, 1'b1, 1'b1, 32'h1001_0000, 32'h1);
        checkOutput("rst_if_gnt", if_gnt1, 0);
        checkOutput("rst_mem_gnt", mem_gnt1, 0);
        checkOutput("rst_ram_cs", ram_cs1, 0);
        checkOutput("rst_ram_we", ram_we1, 0);
        checkOutput("rst_stall_if", stall_if1, 0);
        checkOutput("rst_stall_mem", stall_mem1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_if_rvalid", if_rvalid1, 0);

        // Back-to-back fetches at RD_LAT=1.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("fetch0_gnt", if_gnt1, 1);
        checkOutput("fetch0_addr", ram_addr1, 32'h0040_0020);
        checkOutput("fetch0_cs", ram_cs1, 1);
        checkOutput("fetch0_rvalid", if_rvalid1, 0);
        checkOutput("fetch0_stall", stall_if1, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0024, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("fetch1_gnt", if_gnt1, 1);
        checkOutput("fetch1_rvalid", if_rvalid1, 1);
        checkOutput("fetch1_rdata", if_rdata1, 32'hC0DE_0008);
        checkOutput("fetch1_stall", stall_if1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("fetch2_rvalid", if_rvalid1, 1);
        checkOutput("fetch2_rdata", if_rdata1, 32'hC0DE_0009);
        checkOutput("fetch2_stall", stall_if1, 0);

        // Load and fetch collide: MEM first, IF next cycle alongside the load data.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0028, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
        checkOutput("conf_mem_gnt", mem_gnt1, 1);
        checkOutput("conf_if_gnt", if_gnt1, 0);
        checkOutput("conf_stall_if", stall_if1, 1);
        checkOutput("conf_ram_addr", ram_addr1, 32'h1001_0000);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0028, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("conf2_mem_rvalid", mem_rvalid1, 1);
        checkOutput("conf2_mem_rdata", mem_rdata1, 32'hC0DE_0000);
        checkOutput("conf2_if_rvalid", if_rvalid1, 0);
        checkOutput("conf2_if_gnt", if_gnt1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("conf3_if_rvalid", if_rvalid1, 1);
        checkOutput("conf3_if_rdata", if_rdata1, 32'hC0DE_000A);

        // Starvation: after four denials IF takes exactly one cycle.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0030, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
            checkOutput($sformatf("starve_if_gnt_c%0d", i), if_gnt1, (i == 5));
            checkOutput($sformatf("starve_mem_gnt_c%0d", i), mem_gnt1, (i != 5));
            checkOutput($sformatf("starve_stall_if_c%0d", i), stall_if1, (i != 5));
            checkOutput($sformatf("starve_stall_mem_c%0d", i), stall_mem1, (i == 5));
            checkOutput($sformatf("starve_mem_rvalid_c%0d", i), mem_rvalid1, (i >= 2 && i != 6));
            checkOutput($sformatf("starve_if_rvalid_c%0d", i), if_rvalid1, (i == 6));
        end
        checkOutput("starve_if_rdata", if_rdata1, 32'hC0DE_000C);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("starve_tail_rvalid", mem_rvalid1, 1);
        checkOutput("starve_tail_rdata", mem_rdata1, 32'hC0DE_0000);

        // Store, read it back, then a store in the cycle the load returns.
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1001_0004, 32'hDEAD_BEEF);
        checkOutput("st_gnt", mem_gnt1, 1);
        checkOutput("st_cs", ram_cs1, 1);
        checkOutput("st_we", ram_we1, 1);
        checkOutput("st_din", ram_din1, 32'hDEAD_BEEF);
        checkOutput("st_addr", ram_addr1, 32'h1001_0004);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
        checkOutput("ld_gnt", mem_gnt1, 1);
        checkOutput("st_no_rvalid", mem_rvalid1, 0);
        checkOutput("ld_ram_we", ram_we1, 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h1001_0008, 32'h1234_5678);
        checkOutput("ld_rvalid", mem_rvalid1, 1);
        checkOutput("ld_rdata", mem_rdata1, 32'hDEAD_BEEF);
        checkOutput("st2_gnt", mem_gnt1, 1);
        checkOutput("st2_we", ram_we1, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("st2_no_rvalid", mem_rvalid1, 0);
        checkOutput("st2_busy", busy1, 0);

        // Three-cycle latency: load blocks a queued fetch until its data returns.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0000, 32'h0);
        checkOutput("lat3_mem_gnt", mem_gnt3, 1);
        checkOutput("lat3_busy_n", busy3, 0);
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("lat3_busy_n%0d", i), busy3, 1);
            checkOutput($sformatf("lat3_stall_mem_n%0d", i), stall_mem3, 1);
            checkOutput($sformatf("lat3_if_gnt_n%0d", i), if_gnt3, 0);
            checkOutput($sformatf("lat3_stall_if_n%0d", i), stall_if3, 1);
            checkOutput($sformatf("lat3_rvalid_n%0d", i), mem_rvalid3, 0);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h0040_0020, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("lat3_rvalid_n3", mem_rvalid3, 1);
        checkOutput("lat3_rdata_n3", mem_rdata3, 32'hC0DE_0000);
        checkOutput("lat3_if_gnt_n3", if_gnt3, 1);
        checkOutput("lat3_busy_n3", busy3, 0);
        checkOutput("lat3_stall_mem_n3", stall_mem3, 0);
        checkOutput("lat3_stall_if_n3", stall_if3, 0);
        for (int i = 4; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("lat3_if_rvalid_n%0d", i), if_rvalid3, (i == 6));
            checkOutput($sformatf("lat3_stall_if_n%0d", i), stall_if3, (i != 6));
            checkOutput($sformatf("lat3_busy_n%0d", i), busy3, (i != 6));
        end
        checkOutput("lat3_if_rdata", if_rdata3, 32'hC0DE_0008);

        // Reset while a three-cycle read is in flight: its data must never surface.
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
        checkOutput("rmid_gnt", mem_gnt3, 1);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h0040_0020, 1'b1, 1'b0, 32'h1001_0004, 32'h0);
        checkOutput("rmid_rst_mem_gnt", mem_gnt3, 0);
        checkOutput("rmid_rst_if_gnt", if_gnt3, 0);
        checkOutput("rmid_rst_busy", busy3, 0);
        checkOutput("rmid_rst_stall_mem", stall_mem3, 0);
        checkOutput("rmid_rst_cs", ram_cs3, 0);
        for (int i = 2; i <= 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
            checkOutput($sformatf("rmid_rvalid_n%0d", i), mem_rvalid3, 0);
            checkOutput($sformatf("rmid_busy_n%0d", i), busy3, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
